// File: rtl/br_pkg.sv
// Shared definitions for the branch unit: opcode and FSM encodings, the PC increment,
// and the branch-target arithmetic.
package br_pkg;

   typedef enum logic [2:0] {
      BrBeq  = 3'd0,
      BrBne  = 3'd1,
      BrBgtz = 3'd2,
      BrBlez = 3'd3,
      BrBgez = 3'd4,
      BrBltz = 3'd5
   } br_op_e;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StWaitOpnd = 2'd1,
      StRedirect = 2'd2
   } br_state_e;

   localparam logic [31:0] PcIncr = 32'd4;

   // imm16 counts words; the sum wraps modulo 2^32.
   function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
      return pc + PcIncr + {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/branch_unit_if.sv
// ID-stage <-> branch unit signal bundle; the master side is the decode stage, the slave
// side is the branch unit.
interface branch_unit_if #(
   parameter int unsigned CNT_W = 32
);

   logic             op_valid;
   logic [2:0]       br_op;
   logic             larger;
   logic             equal;
   logic             smaller;
   logic             operands_ready;
   logic [31:0]      pc_id;
   logic [15:0]      imm16;
   logic             flush;
   logic             redirect_ack;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic             stall_id;
   logic             resolved;
   logic             taken;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] taken_cnt;

   modport master (
      output op_valid, br_op, larger, equal, smaller, operands_ready, pc_id, imm16, flush,
             redirect_ack,
      input  redirect_valid, redirect_pc, stall_id, resolved, taken, br_cnt, taken_cnt
   );

   modport slave (
      input  op_valid, br_op, larger, equal, smaller, operands_ready, pc_id, imm16, flush,
             redirect_ack,
      output redirect_valid, redirect_pc, stall_id, resolved, taken, br_cnt, taken_cnt
   );

endinterface

// File: rtl/branch_cond.sv
// Combinational branch-condition decode from the signed compare flags.
module branch_cond
   import br_pkg::*;
(
   input  logic [2:0] i_br_op,
   input  logic       i_larger,
   input  logic       i_equal,
   input  logic       i_smaller,
   output logic       o_cond
);

   always_comb begin
      o_cond = 1'b0;
      case (i_br_op)
         BrBeq:   o_cond = i_equal;
         BrBne:   o_cond = !i_equal;
         BrBgtz:  o_cond = i_larger;
         BrBlez:  o_cond = !i_larger;
         BrBgez:  o_cond = !i_smaller;
         BrBltz:  o_cond = i_smaller;
         default: o_cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_unit.sv
// ID-stage branch resolution: waits for final operands, decides direction, holds a taken
// target until fetch accepts it, and keeps resolved/taken statistics.
module branch_unit
   import br_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic          clk,
   input  logic          reset,
   branch_unit_if.slave  bus
);

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   br_state_e        r_state;
   br_state_e        w_state_next;
   logic             w_cond;
   logic             w_decide;
   logic             w_stall;
   logic             r_resolved;
   logic             r_taken;
   logic [31:0]      r_redirect_pc;
   logic [CNT_W-1:0] r_br_cnt;
   logic [CNT_W-1:0] r_taken_cnt;

   branch_cond u_cond (
      .i_br_op   (bus.br_op),
      .i_larger  (bus.larger),
      .i_equal   (bus.equal),
      .i_smaller (bus.smaller),
      .o_cond    (w_cond)
   );

   always_comb begin
      w_state_next = r_state;
      w_decide     = 1'b0;
      w_stall      = 1'b0;
      unique case (r_state)
         StIdle, StWaitOpnd: begin
            w_stall = (r_state == StWaitOpnd) || (bus.op_valid && !bus.operands_ready);
            if (!bus.op_valid) begin
               w_state_next = StIdle;
            end else if (bus.operands_ready) begin
               w_decide     = 1'b1;
               w_state_next = w_cond ? StRedirect : StIdle;
            end else begin
               w_state_next = StWaitOpnd;
            end
         end
         StRedirect: begin
            w_stall = 1'b1;
            if (bus.redirect_ack) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
      // Flush wins over any decision or acknowledge in the same cycle.
      if (bus.flush) begin
         w_state_next = StIdle;
         w_decide     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= StIdle;
         r_resolved    <= 1'b0;
         r_taken       <= 1'b0;
         r_redirect_pc <= '0;
         r_br_cnt      <= '0;
         r_taken_cnt   <= '0;
      end else begin
         r_state    <= w_state_next;
         r_resolved <= w_decide;
         if (w_decide) begin
            r_taken  <= w_cond;
            r_br_cnt <= r_br_cnt + CntOne;
            if (w_cond) begin
               r_taken_cnt   <= r_taken_cnt + CntOne;
               r_redirect_pc <= branch_target(bus.pc_id, bus.imm16);
            end
         end
      end
   end

   assign bus.redirect_valid = (r_state == StRedirect);
   assign bus.redirect_pc    = r_redirect_pc;
   assign bus.stall_id       = w_stall;
   assign bus.resolved       = r_resolved;
   assign bus.taken          = r_taken;
   assign bus.br_cnt         = r_br_cnt;
   assign bus.taken_cnt      = r_taken_cnt;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: stimulus pushes expected decisions into a queue, a monitor
// pops and compares them on every resolved pulse.
module tb_branch_unit;

   localparam int unsigned CW = 4;

   typedef struct packed {
      logic          taken;
      logic [31:0]   pc;
      logic [CW-1:0] br;
      logic [CW-1:0] tk;
   } exp_t;

   logic          clk;
   logic          reset;
   exp_t          sb_q[$];
   exp_t          mon_e;
   logic [CW-1:0] exp_br;
   logic [CW-1:0] exp_tk;
   int            n_checks;
   int            n_errors;

   branch_unit_if #(.CNT_W(CW)) bus ();

   branch_unit #(.CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every resolved pulse must match the oldest expected decision.
   always @(negedge clk) begin
      if (bus.resolved === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_resolve: got resolved=1 expected none at %0t", $time);
         end else begin
            mon_e = sb_q.pop_front();
            chk("taken", 32'(bus.taken), 32'(mon_e.taken));
            chk("br_cnt", 32'(bus.br_cnt), 32'(mon_e.br));
            chk("taken_cnt", 32'(bus.taken_cnt), 32'(mon_e.tk));
            chk("redirect_valid_at_resolve", 32'(bus.redirect_valid), 32'(mon_e.taken));
            if (mon_e.taken) chk("redirect_pc", bus.redirect_pc, mon_e.pc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      exp_br = '0;
      exp_tk = '0;
   endtask

   task automatic redirect(input logic [31:0] exp_pc, input int hold, input logic use_flush);
      // Decode-side noise while redirecting must be ignored.
      for (int i = 0; i < hold; i++) begin
         bus.op_valid       = 1'b1;
         bus.operands_ready = 1'b1;
         bus.br_op          = 3'(i);
         @(negedge clk);
         chk("redirect_valid_hold", 32'(bus.redirect_valid), 32'd1);
         chk("redirect_pc_hold", bus.redirect_pc, exp_pc);
         chk("stall_redirect", 32'(bus.stall_id), 32'd1);
         step();
      end
      bus.op_valid       = 1'b0;
      bus.operands_ready = 1'b0;
      bus.redirect_ack   = 1'b1;
      bus.flush          = use_flush;
      @(negedge clk);
      chk("redirect_valid_ack_cycle", 32'(bus.redirect_valid), 32'd1);
      step();
      bus.redirect_ack = 1'b0;
      bus.flush        = 1'b0;
      @(negedge clk);
      chk("redirect_valid_after_ack", 32'(bus.redirect_valid), 32'd0);
      chk("stall_after_ack", 32'(bus.stall_id), 32'd0);
      step();
   endtask

   task automatic branch(input logic [2:0] op, input logic lg, input logic eq, input logic sm,
                         input logic [31:0] pc, input logic [15:0] imm, input int delay,
                         input logic exp_taken, input logic [31:0] exp_pc, input int hold,
                         input logic use_flush);
      bus.br_op          = op;
      bus.larger         = lg;
      bus.equal          = eq;
      bus.smaller        = sm;
      bus.pc_id          = pc;
      bus.imm16          = imm;
      bus.op_valid       = 1'b1;
      bus.operands_ready = (delay == 0);
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         chk("stall_wait", 32'(bus.stall_id), 32'd1);
         step();
      end
      bus.operands_ready = 1'b1;
      exp_br = exp_br + 1'b1;
      if (exp_taken) exp_tk = exp_tk + 1'b1;
      sb_q.push_back('{taken: exp_taken, pc: exp_pc, br: exp_br, tk: exp_tk});
      @(negedge clk);
      chk("stall_decide", 32'(bus.stall_id), 32'(delay > 0));
      step();
      bus.op_valid       = 1'b0;
      bus.operands_ready = 1'b0;
      if (exp_taken) begin
         redirect(exp_pc, hold, use_flush);
      end else begin
         @(negedge clk);
         chk("no_redirect", 32'(bus.redirect_valid), 32'd0);
         step();
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      exp_br = '0;
      exp_tk = '0;
      reset = 1'b1;
      bus.op_valid = 1'b0;
      bus.br_op = 3'd0;
      bus.larger = 1'b0;
      bus.equal = 1'b0;
      bus.smaller = 1'b0;
      bus.operands_ready = 1'b0;
      bus.pc_id = 32'd0;
      bus.imm16 = 16'd0;
      bus.flush = 1'b0;
      bus.redirect_ack = 1'b0;
      step();
      step();
      @(negedge clk);
      chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
      chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
      chk("rst_resolved", 32'(bus.resolved), 32'd0);
      chk("rst_taken", 32'(bus.taken), 32'd0);
      chk("rst_br_cnt", 32'(bus.br_cnt), 32'd0);
      chk("rst_taken_cnt", 32'(bus.taken_cnt), 32'd0);
      chk("rst_stall", 32'(bus.stall_id), 32'd0);
      step();
      reset = 1'b0;

      //     op    lg    eq    sm    pc            imm       dly taken target       hold flush
      branch(3'd0, 1'b0, 1'b1, 1'b0, 32'h00003000, 16'h0004, 0, 1'b1, 32'h00003014, 1, 1'b0);
      branch(3'd1, 1'b0, 1'b1, 1'b0, 32'h00003000, 16'h0004, 0, 1'b0, 32'h0,        0, 1'b0);
      branch(3'd5, 1'b0, 1'b0, 1'b1, 32'h00003000, 16'hFFFF, 3, 1'b1, 32'h00003000, 0, 1'b0);
      branch(3'd2, 1'b1, 1'b0, 1'b0, 32'h00001000, 16'h0002, 0, 1'b1, 32'h0000100C, 0, 1'b0);
      branch(3'd3, 1'b1, 1'b0, 1'b0, 32'h00001000, 16'h0002, 0, 1'b0, 32'h0,        0, 1'b0);
      branch(3'd4, 1'b0, 1'b1, 1'b0, 32'h00002000, 16'hFFFE, 1, 1'b1, 32'h00001FFC, 0, 1'b0);
      branch(3'd7, 1'b1, 1'b1, 1'b1, 32'h00002000, 16'h0001, 0, 1'b0, 32'h0,        0, 1'b0);
      branch(3'd0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFF0, 16'h0010, 0, 1'b1, 32'h00000034, 5, 1'b1);
      @(negedge clk);
      chk("no_second_redirect", 32'(bus.redirect_valid), 32'd0);
      step();

      // Flush suppresses a same-cycle decision.
      bus.br_op = 3'd0;
      bus.equal = 1'b1;
      bus.op_valid = 1'b1;
      bus.operands_ready = 1'b1;
      bus.flush = 1'b1;
      step();
      bus.op_valid = 1'b0;
      bus.operands_ready = 1'b0;
      bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_no_resolve", 32'(bus.resolved), 32'd0);
      chk("flush_no_redirect", 32'(bus.redirect_valid), 32'd0);

      // op_valid dropping in WAIT_OPND returns to IDLE; a stray ack in IDLE is ignored.
      step();
      bus.op_valid = 1'b1;
      step();
      bus.op_valid = 1'b0;
      bus.redirect_ack = 1'b1;
      @(negedge clk);
      chk("wait_drop_stall", 32'(bus.stall_id), 32'd1);
      step();
      bus.redirect_ack = 1'b0;
      @(negedge clk);
      chk("wait_drop_idle", 32'(bus.stall_id), 32'd0);
      chk("stray_ack", 32'(bus.redirect_valid), 32'd0);
      chk("wait_drop_cnt", 32'(bus.br_cnt), 32'(exp_br));
      step();

      // Counter wrap at CNT_W=4: 17 taken branches from reset.
      do_reset();
      for (int i = 0; i < 17; i++)
         branch(3'd0, 1'b0, 1'b1, 1'b0, 32'h00000100, 16'h0000, 0, 1'b1, 32'h00000104, 0, 1'b0);
      @(negedge clk);
      chk("wrap_br_cnt", 32'(bus.br_cnt), 32'd1);
      chk("wrap_taken_cnt", 32'(bus.taken_cnt), 32'd1);
      step();

      // Reset in WAIT_OPND, overriding a simultaneous flush.
      bus.br_op = 3'd5;
      bus.op_valid = 1'b1;
      bus.operands_ready = 1'b0;
      step();
      reset = 1'b1;
      bus.flush = 1'b1;
      bus.op_valid = 1'b0;
      step();
      reset = 1'b0;
      bus.flush = 1'b0;
      exp_br = '0;
      exp_tk = '0;
      @(negedge clk);
      chk("rst_wait_stall", 32'(bus.stall_id), 32'd0);
      chk("rst_wait_br_cnt", 32'(bus.br_cnt), 32'd0);
      chk("rst_wait_taken_cnt", 32'(bus.taken_cnt), 32'd0);
      chk("rst_wait_redirect_pc", bus.redirect_pc, 32'd0);
      chk("rst_wait_taken", 32'(bus.taken), 32'd0);
      step();

      // Reset while in REDIRECT drops the pending redirect.
      bus.br_op = 3'd0;
      bus.equal = 1'b1;
      bus.pc_id = 32'h00004000;
      bus.imm16 = 16'h0001;
      bus.op_valid = 1'b1;
      bus.operands_ready = 1'b1;
      exp_br = exp_br + 1'b1;
      exp_tk = exp_tk + 1'b1;
      sb_q.push_back('{taken: 1'b1, pc: 32'h00004008, br: exp_br, tk: exp_tk});
      step();
      bus.op_valid = 1'b0;
      bus.operands_ready = 1'b0;
      @(negedge clk);
      chk("pre_rst_redirect", 32'(bus.redirect_valid), 32'd1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_redirect_drop", 32'(bus.redirect_valid), 32'd0);
      chk("rst_redirect_pc_clr", bus.redirect_pc, 32'd0);
      chk("rst_redirect_stall", 32'(bus.stall_id), 32'd0);

      step();
      @(negedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the statistics counters.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port op_valid, input, 1: the ID stage holds a branch instruction.
REQ-005 SHALL have port br_op, input, 3: branch type per package encoding (BEQ, BNE, BGTZ, BLEZ, BGEZ, BLTZ).
REQ-006 SHALL have ports larger, equal, smaller, input, 1 each: signed compare flags of SrcA vs SrcB from the ID comparator.
REQ-007 SHALL have port operands_ready, input, 1: forwarded SrcA and SrcB are final this cycle.
REQ-008 SHALL have port pc_id, input, 32: PC of the branch.
REQ-009 SHALL have port imm16, input, 16: branch offset in words.
REQ-010 SHALL have port flush, input, 1: exception or pipeline flush.
REQ-011 SHALL have port redirect_ack, input, 1: fetch accepts redirect_pc this cycle.
REQ-012 SHALL have port redirect_valid, output, 1: a taken-branch target is pending.
REQ-013 SHALL have port redirect_pc, output, 32: branch target.
REQ-014 SHALL have port stall_id, output, 1: hold the ID stage.
REQ-015 SHALL have port resolved, output, 1: one-cycle pulse when a branch decision is made.
REQ-016 SHALL have port taken, output, 1: direction of the latest decision, valid with resolved.
REQ-017 SHALL have ports br_cnt and taken_cnt, output, CNT_W each: resolved-branch and taken-branch counts.

Function
REQ-018 SHALL evaluate the branch condition as follows: BEQ=equal, BNE=!equal, BGTZ=larger, BLEZ=!larger, BGEZ=!smaller, BLTZ=smaller.
REQ-019 SHALL treat an undefined br_op as not-taken.
REQ-020 SHALL compute the target as pc_id + 4 + (sign_extend(imm16) << 2), modulo 2^32, with wrap-around permitted.
REQ-021 SHALL implement FSM states IDLE, WAIT_OPND and REDIRECT.
REQ-022 In IDLE, when op_valid is high and operands_ready is low, the unit SHALL go to WAIT_OPND.
REQ-023 In IDLE or WAIT_OPND, when op_valid and operands_ready are both high, the unit SHALL decide in that cycle: resolved is asserted for one registered cycle (asserted the next cycle), and taken is registered alongside it.
REQ-024 On a taken decision the unit SHALL go to REDIRECT with redirect_pc registered; otherwise it SHALL go to IDLE.
REQ-025 In REDIRECT, redirect_valid SHALL be 1 and redirect_pc SHALL stay stable until the cycle redirect_ack is high; the unit SHALL then return to IDLE on the next edge.
REQ-026 redirect_valid SHALL be 0 in every other state.
REQ-027 stall_id SHALL be combinational and equal to: (state==WAIT_OPND) OR (state==REDIRECT) OR (state==IDLE AND op_valid AND NOT operands_ready).
REQ-028 Changes to op_valid or br_op while in REDIRECT SHALL be ignored.
REQ-029 If op_valid drops while in WAIT_OPND, the unit SHALL return to IDLE without resolving.
REQ-030 flush SHALL force IDLE on the next edge from any state, drop a pending redirect, and suppress a decision in the same cycle; flush SHALL take priority over a simultaneous redirect_ack or decision.
REQ-031 On each resolved pulse, br_cnt SHALL increment by 1, and taken_cnt SHALL increment by 1 when taken is high; both SHALL wrap at 2^CNT_W.
REQ-032 If redirect_ack is asserted while redirect_valid is 0, it SHALL be ignored.

Reset
REQ-033 On reset the unit SHALL enter IDLE with redirect_valid=0, redirect_pc=0, resolved=0, taken=0, br_cnt=0 and taken_cnt=0.
REQ-034 Reset SHALL override flush and all other inputs.
REQ-035 Reset in REDIRECT SHALL drop the pending redirect.

Structure
REQ-036 The br_op encodings, the FSM state encodings and the PC increment constant (4) SHALL live in the shared package br_pkg.
REQ-037 The condition evaluation (REQ-018/019) SHALL be the combinational sub-module branch_cond (inputs: br_op and the three flags; output: cond).

Verification
REQ-038 Scenario: BEQ, equal=1, operands_ready=1, pc_id=0x00003000, imm16=0x0004 -> next cycle resolved=1, taken=1, redirect_valid=1, redirect_pc=0x00003014; ack in cycle 3 -> IDLE.
REQ-039 Scenario: BNE, equal=1 -> resolved=1, taken=0, redirect_valid stays 0, br_cnt=1, taken_cnt=0.
REQ-040 Scenario: BLTZ with operands_ready low for 3 cycles then smaller=1 -> stall_id=1 for all 3 cycles, then taken redirect; imm16=0xFFFF with pc_id=0x00003000 -> redirect_pc=0x00003000.
REQ-041 Scenario: in REDIRECT, redirect_ack held low for 5 cycles -> redirect_pc stable and stall_id=1 throughout; flush and redirect_ack asserted together -> IDLE, redirect_valid=0, no second redirect.
REQ-042 Scenario: pc_id=0xFFFFFFF0, imm16=0x0010 -> redirect_pc=0x00000034 (wraps).
REQ-043 Scenario: CNT_W=4, 17 taken branches -> br_cnt=1, taken_cnt=1; reset asserted while in WAIT_OPND -> IDLE and all outputs 0.
